// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state type and message length helper.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} parser_state_t;

  // Number of data bytes following a channel status byte of the given type.
  function automatic logic [1:0] data_bytes(input logic [3:0] kind);
    data_bytes = (kind == PROG || kind == CHAN_AT) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_note_parser.sv
// Monophonic MIDI parser: turns a UART byte stream into note index, velocity and gate.
module midi_note_parser
  import midi_pkg::*;
#(
  parameter int unsigned ADDR_WDTH = 7,
  parameter int unsigned CHANNEL   = 0,
  parameter int unsigned OMNI      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [ADDR_WDTH-1:0] note,
  output logic [6:0]           velocity,
  output logic                 gate,
  output logic                 note_strobe
);

  parser_state_t state_q;
  logic [3:0]    kind_q;
  logic [3:0]    chan_q;
  logic [6:0]    d1_q;

  logic                 is_data, is_syscom, is_status, is_realtime;
  logic                 msg_done, chan_ok;
  logic [6:0]           msg_d1, msg_d2;
  logic [ADDR_WDTH-1:0] d1_note;
  logic                 do_note_on, do_note_off, do_all_off;

  always_comb begin
    is_data     = ~rx_data[7];
    is_realtime = rx_data[7:3] == 5'b11111;
    is_syscom   = rx_data[7:3] == 5'b11110;
    is_status   = rx_data[7] && rx_data[7:4] != 4'hF;
    chan_ok     = (OMNI != 0) || (chan_q == 4'(CHANNEL));
    msg_done    = rx_valid && is_data &&
                  ((state_q == WAIT_D1 && data_bytes(kind_q) == 2'd1) || state_q == WAIT_D2);
    // Single-data-byte messages complete on d1 with an implied zero d2.
    msg_d1      = (state_q == WAIT_D2) ? d1_q : rx_data[6:0];
    msg_d2      = (state_q == WAIT_D2) ? rx_data[6:0] : 7'd0;
    d1_note     = ADDR_WDTH'(msg_d1);
    do_note_on  = msg_done && chan_ok && kind_q == NOTE_ON && msg_d2 != 7'd0;
    do_note_off = msg_done && chan_ok && gate && d1_note == note &&
                  (kind_q == NOTE_OFF || (kind_q == NOTE_ON && msg_d2 == 7'd0));
    do_all_off  = msg_done && chan_ok && kind_q == CC && msg_d1 == CC_ALL_NOTES_OFF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      kind_q      <= 4'h0;
      chan_q      <= 4'h0;
      d1_q        <= 7'd0;
      note        <= '0;
      velocity    <= 7'd0;
      gate        <= 1'b0;
      note_strobe <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      if (rx_valid && !is_realtime) begin
        if (is_syscom) begin
          state_q <= IDLE;
          kind_q  <= 4'h0;
          chan_q  <= 4'h0;
        end else if (is_status) begin
          state_q <= WAIT_D1;
          kind_q  <= rx_data[7:4];
          chan_q  <= rx_data[3:0];
        end else begin
          unique case (state_q)
            WAIT_D1: begin
              d1_q <= rx_data[6:0];
              if (data_bytes(kind_q) != 2'd1) state_q <= WAIT_D2;
            end
            WAIT_D2: state_q <= WAIT_D1;
            default: ;
          endcase
        end
      end

      if (do_note_on) begin
        note        <= d1_note;
        velocity    <= msg_d2;
        gate        <= 1'b1;
        note_strobe <= 1'b1;
      end else if (do_note_off) begin
        gate        <= 1'b0;
        note_strobe <= 1'b1;
      end else if (do_all_off) begin
        gate        <= 1'b0;
        note_strobe <= gate;
      end
    end
  end

endmodule

// File: doc/midi_note_parser.md
Name: midi_note_parser

Overview:
- Parses a MIDI byte stream from the UART receiver into a single monophonic note.
- Drives the note index into note_lookup, plus gate and velocity to the DDS voice.
- Sits directly upstream of note_lookup. note_lookup adds one further clock of ROM latency before the phase increment is available.

Parameters:
- ADDR_WDTH, 7, width of the note index; must match note_lookup ADDR_WDTH.
- CHANNEL, 0, MIDI channel (0-15) the parser responds to.
- OMNI, 0, when 1, respond to all channels and ignore CHANNEL.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  one-cycle strobe; rx_data valid this cycle
- note  output  ADDR_WDTH  current/last note index; feeds note_lookup address
- velocity  output  7  velocity of the current note
- gate  output  1  high while a note is held
- note_strobe  output  1  one-cycle pulse whenever note, velocity or gate changes

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low.
- Reset values: note=0, velocity=0, gate=0, note_strobe=0, state=IDLE, running status cleared.
- Reset asserted mid-message discards all partial state.
- Bytes are sampled only when rx_valid=1. All other cycles hold state.
- Byte classes:
  - Data byte: bit7=0.
  - Channel status: 0x80-0xEF.
  - System common: 0xF0-0xF7.
  - Realtime: 0xF8-0xFF.
- Realtime bytes are ignored entirely. They may arrive between any two bytes without disturbing parsing.
- System common bytes clear running status and enter IDLE. Following data bytes are discarded until the next channel status byte.
- Channel status byte:
  - Latches running status (type nibble and channel), enters WAIT_D1.
  - Abandons any partially received message.
  - Channel mismatch (OMNI=0): status is still latched, but the completed message is discarded.
- States:
  - IDLE: data bytes discarded.
  - WAIT_D1: data byte latched as d1. Types 0xC and 0xD complete here (one data byte) and return to WAIT_D1. All other types go to WAIT_D2.
  - WAIT_D2: data byte latched as d2, message completes, return to WAIT_D1 (running status retained).
- Message actions on completion, channel matching:
  - Note on (0x9), d2!=0: note<=d1, velocity<=d2, gate<=1, note_strobe=1. Last-note priority: a new note-on replaces any held note.
  - Note off (0x8, or 0x9 with d2=0): if gate=1 and d1==note, then gate<=0 and note_strobe=1. note and velocity hold. Otherwise no effect.
  - Control change (0xB), d1=123 (all notes off): gate<=0, and note_strobe=1 if gate was 1.
  - Any other type: consumed, no effect.
- Latency: outputs and note_strobe update on the clk edge after the cycle in which the final data byte has rx_valid=1.
- note_strobe is high for exactly one cycle and never for a message with no effect.
- Back-to-back rx_valid on consecutive cycles must be supported with no byte dropped.
- Width rules:
  - d1 is 7 bits; note takes its low ADDR_WDTH bits, zero-extended if ADDR_WDTH>7.
  - velocity is d2[6:0].

Decomposition:
- Shared package midi_pkg:
  - Status type constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, POLY_AT=4'hA, CC=4'hB, PROG=4'hC, CHAN_AT=4'hD, PITCH=4'hE.
  - CC_ALL_NOTES_OFF=7'd123.
  - Parser state enum: IDLE, WAIT_D1, WAIT_D2.
  - A function returning the data-byte count for a status nibble.
- Single module; no sub-module needed. Byte classification is a few combinational lines inside the parser.

Test Plan:
- Reset then bytes 0x90,0x3C,0x64 -> one cycle after the last byte: note=60, velocity=100, gate=1, note_strobe pulses once.
- Running status: 0x90,0x3C,0x64 then 0x40,0x50 -> second note-on gives note=64, velocity=80, gate=1; then 0x40,0x00 -> gate=0, note stays 64.
- Note-off for a non-held note: hold 0x3C, send 0x80,0x3E,0x00 -> gate stays 1, no note_strobe. Then 0x80,0x3C,0x40 -> gate=0.
- Realtime interleave: 0x90,0xF8,0x3C,0xFE,0x64 -> same result as scenario 1.
- Interrupted message: 0x90,0x3C,0xC0,0x05, then 0x45,0x30 -> no note-on from the partial message; gate stays 0 (program change 0xC0 active). Then 0xB0,0x7B,0x00 with gate=1 -> gate=0.
- Channel filter (CHANNEL=0, OMNI=0): 0x91,0x3C,0x64 -> no change. Reset asserted mid-message (after 0x90,0x3C), then 0x64 -> all outputs at reset values, byte discarded.
